// File: rtl/vga_sync_rx.sv
// Receive side of a VGA link: recovers (x,y) from hsync/vsync, measures line and
// frame totals, and locks when both match the configured mode.
module vga_sync_rx #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC_START = 657,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC_START = 491,
  localparam int unsigned XW = 10,
  localparam int unsigned CW = 11,
  localparam int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [RW-1:0] rgb,
  output logic [XW-1:0] x,
  output logic [XW-1:0] y,
  output logic [RW-1:0] pix_rgb,
  output logic          pix_valid,
  output logic          frame_start,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] meas_h_total,
  output logic [CW-1:0] meas_v_total
);

  localparam logic [CW-1:0] SAT   = '1;
  localparam logic [CW-1:0] HT_C  = CW'(H_TOTAL);
  localparam logic [CW-1:0] HT_P1 = CW'(H_TOTAL + 1);
  localparam logic [CW-1:0] VT_C  = CW'(V_TOTAL);
  localparam logic [CW-1:0] VT_P1 = CW'(V_TOTAL + 1);

  typedef enum logic [1:0] {SEARCH, SYNC_H, LOCKED} state_e;

  state_e        state_q, state_d;
  logic          s_hs_q, s_vs_q, prev_hs_q, prev_vs_q;
  logic [RW-1:0] s_rgb_q;
  logic          hrise, vrise, x_wrap, h_bad, l_bad;
  logic [XW-1:0] x_q, x_d, y_q, y_d;
  logic          run_q, run_d, v_seen_q, v_seen_d, locked_q, locked_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d, l_cnt_q, l_cnt_d;
  logic [CW-1:0] meas_h_q, meas_h_d, meas_v_q, meas_v_d;
  logic [RW-1:0] pix_rgb_q, pix_rgb_d;
  logic          pix_valid_q, pix_valid_d, frame_start_q, frame_start_d, err_q, err_d;

  // Stage 1: input capture plus previous sync levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_hs_q    <= 1'b0;
      s_vs_q    <= 1'b0;
      prev_hs_q <= 1'b0;
      prev_vs_q <= 1'b0;
      s_rgb_q   <= '0;
    end else if (pix_ce) begin
      s_hs_q    <= hsync;
      s_vs_q    <= vsync;
      prev_hs_q <= s_hs_q;
      prev_vs_q <= s_vs_q;
      s_rgb_q   <= rgb;
    end
  end

  assign hrise = s_hs_q & ~prev_hs_q;
  assign vrise = s_vs_q & ~prev_vs_q;

  // Stage 2: counters, measurement, lock FSM and output staging
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    run_d         = run_q;
    v_seen_d      = v_seen_q;
    locked_d      = locked_q;
    h_cnt_d       = h_cnt_q;
    l_cnt_d       = l_cnt_q;
    meas_h_d      = meas_h_q;
    meas_v_d      = meas_v_q;
    pix_rgb_d     = pix_rgb_q;
    pix_valid_d   = pix_valid_q;
    frame_start_d = 1'b0;
    err_d         = 1'b0;
    x_wrap        = 1'b0;
    h_bad         = 1'b0;
    l_bad         = 1'b0;
    if (pix_ce) begin
      x_wrap = !hrise && (x_q == XW'(H_TOTAL - 1));
      // Coordinates free-run once the first hsync edge has been seen
      if (run_q || hrise) begin
        run_d = 1'b1;
        if (hrise)       x_d = XW'(H_SYNC_START);
        else if (x_wrap) x_d = '0;
        else             x_d = x_q + XW'(1);
        if (vrise)       y_d = XW'(V_SYNC_START);
        else if (x_wrap) y_d = (y_q == XW'(V_TOTAL - 1)) ? '0 : y_q + XW'(1);
      end

      if (hrise) begin
        h_cnt_d  = CW'(1);
        meas_h_d = h_cnt_q;
      end else if (h_cnt_q != SAT) begin
        h_cnt_d = h_cnt_q + CW'(1);
      end

      // A coincident hrise belongs to the frame that vrise opens
      if (vrise) begin
        meas_v_d = l_cnt_q;
        l_cnt_d  = hrise ? CW'(1) : '0;
      end else if (hrise && l_cnt_q != SAT) begin
        l_cnt_d = l_cnt_q + CW'(1);
      end

      h_bad = (hrise && h_cnt_q != HT_C) || (h_cnt_d == HT_P1);
      l_bad = (vrise && l_cnt_q != VT_C) || (l_cnt_d == VT_P1);

      case (state_q)
        SEARCH: begin
          v_seen_d = 1'b0;
          if (hrise) state_d = SYNC_H;
        end
        SYNC_H: begin
          if (h_bad) begin
            state_d  = SEARCH;
            v_seen_d = 1'b0;
          end else if (vrise) begin
            if (v_seen_q && l_cnt_q == VT_C) state_d = LOCKED;
            v_seen_d = 1'b1;
          end
        end
        LOCKED: begin
          if (h_bad || l_bad) begin
            state_d  = SEARCH;
            v_seen_d = 1'b0;
            err_d    = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase

      locked_d      = (state_d == LOCKED);
      pix_valid_d   = locked_d && (x_d < XW'(H_ACTIVE)) && (y_d < XW'(V_ACTIVE));
      pix_rgb_d     = pix_valid_d ? s_rgb_q : '0;
      frame_start_d = locked_d && (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      x_q           <= '0;
      y_q           <= '0;
      run_q         <= 1'b0;
      v_seen_q      <= 1'b0;
      locked_q      <= 1'b0;
      h_cnt_q       <= '0;
      l_cnt_q       <= '0;
      meas_h_q      <= '0;
      meas_v_q      <= '0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      run_q         <= run_d;
      v_seen_q      <= v_seen_d;
      locked_q      <= locked_d;
      h_cnt_q       <= h_cnt_d;
      l_cnt_q       <= l_cnt_d;
      meas_h_q      <= meas_h_d;
      meas_v_q      <= meas_v_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign pix_rgb      = pix_rgb_q;
  assign pix_valid    = pix_valid_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign meas_h_total = meas_h_q;
  assign meas_v_total = meas_v_q;

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

- Receive end of the 640x480@60 VGA link: consumes the hsync/vsync/rgb stream produced by the team's VGA timing generator.
- Recovers pixel coordinates, measures line and frame totals, and declares lock when the timing matches the configured mode.
- Re-emits each active pixel with its (x,y) position.
- Sits in front of capture and verification logic: frame grabbers, self-check of the generator, loopback tests.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel samples per line
- H_SYNC_START, 657, x value of the first sample with hsync high
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, lines per frame
- V_SYNC_START, 491, y value of the first line with vsync high
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel strobe, one clk-wide per pixel (25 MHz rate); all state advances only on clk edges with pix_ce=1
- hsync  in  1  active-high horizontal sync
- vsync  in  1  active-high vertical sync
- rgb  in  3  pixel colour
- x  out  10  recovered column
- y  out  10  recovered line
- pix_rgb  out  3  colour of the sample at (x,y); 0 when pix_valid=0
- pix_valid  out  1  locked and x<H_ACTIVE and y<V_ACTIVE
- frame_start  out  1  one-clk pulse when x=0, y=0 and locked
- locked  out  1  timing matches the parameters
- err  out  1  one-clk pulse on loss of lock
- meas_h_total  out  11  last measured samples per line, saturating at 2047
- meas_v_total  out  11  last measured lines per frame, saturating at 2047

## Operation
- Stage 1, input register: hsync, vsync and rgb are captured into s_hs, s_vs and s_rgb. The previous s_hs/s_vs values are kept for edge detection.
- hrise = s_hs & ~prev_hs. vrise = s_vs & ~prev_vs.
- Stage 2, x counter: on hrise, load H_SYNC_START. Otherwise increment, wrapping from H_TOTAL-1 to 0.
- Stage 2, y counter: on vrise, load V_SYNC_START. Otherwise increment on an x wrap, modulo V_TOTAL. When vrise and an x wrap coincide, vrise wins.
- h_cnt: set to 1 on hrise, else increment, saturating at 2047. On hrise, the old h_cnt is latched into meas_h_total.
- l_cnt: counts hrises, saturating at 2047. On vrise it is latched into meas_v_total, then reset to 0. When hrise and vrise occur on the same sample, that hrise is counted in the new frame.
- hrise and vrise on the same sample are both processed on that sample.
- Lock FSM, state SEARCH: locked=0, v_seen=0. The first hrise moves to SYNC_H.
- Lock FSM, state SYNC_H: locked=0.
  - Return to SEARCH on hrise with h_cnt≠H_TOTAL, or when h_cnt reaches H_TOTAL+1.
  - First vrise sets v_seen.
  - A vrise with v_seen=1 and l_cnt=V_TOTAL moves to LOCKED.
  - A vrise with v_seen=1 and l_cnt≠V_TOTAL keeps v_seen=1 and stays in SYNC_H.
- Lock FSM, state LOCKED: locked=1. Any of the following moves to SEARCH and pulses err:
  - hrise with h_cnt≠H_TOTAL
  - h_cnt reaching H_TOTAL+1 (missing hsync)
  - vrise with l_cnt≠V_TOTAL
  - l_cnt reaching V_TOTAL+1 (missing vsync)
- err fires only when leaving LOCKED, never from SYNC_H.
- pix_valid, pix_rgb and frame_start are gated by locked. x and y run in every state once SYNC_H has been entered.

## Timing
- Reset values: x=0, y=0, pix_rgb=0, pix_valid=0, frame_start=0, locked=0, err=0, meas_h_total=0, meas_v_total=0; FSM in SEARCH.
- Reset is asynchronous. Asserting rst_n mid-frame clears everything immediately; reacquisition restarts from SEARCH.
- Latency: input sample k appears on x, y, pix_rgb and pix_valid after the second pix_ce edge following its presentation.
- All outputs are registered. Outputs hold when pix_ce=0.
- frame_start and err are high for exactly one clk, and only on a pix_ce edge.
- Minimum lock time against a freshly reset generator: first vrise at line 491, then V_TOTAL lines later, i.e. (491+525)*800 pixel samples plus 2.

## Test plan
- Generator at reset defaults, pix_ce every second clk -> locked rises (491+525)*800+2 pixel strobes after the generator starts; meas_h_total=800, meas_v_total=525; err never fires.
- Locked, generator drives green -> pix_valid asserted for exactly 640*480 strobes per frame with pix_rgb=3'b010; frame_start once per 420000 strobes, coincident with x=0, y=0.
- Locked, one hsync pulse suppressed -> err pulses once when h_cnt reaches 801; locked=0; relock after two further vsync rises.
- Locked, generator switched to 799-sample lines -> err at the next hrise; meas_h_total=799; locked stays 0.
- Locked, rst_n pulsed low for 3 clks mid-line -> all outputs 0 asynchronously; lock regained one full frame after the next vsync rise.
- pix_ce held low for 100 clks mid-frame -> x, y and all outputs frozen; no frame_start or err pulses.
